mmh_modmul_stage: RTL
=====================

// Module: mmh_modmul_stage
// PURPOSE
//  Upstream neighbour of the MMH modular summation stage in the privacy-amplification hash.
//  Per block, computes y_i = (m_i * k_i) mod P for K message/key element pairs.
//  Evaluates one element per cycle on a single multiplier, then presents all K results as
//  one flattened vector with a 1-cycle valid pulse, ready for the summation stage.
// PARAMETERS
//  GAMMA  13      bit-width of each message/key/result element
//  K      16      elements per block
//  P      64'h7F  prime modulus; must satisfy 2 <= P < 2^GAMMA
// PORTS
//  clk       in   1          clock, rising edge
//  rst       in   1          reset, asynchronous, active-high
//  valid_in  in   1          block offered on msg_in/key_in
//  in_ready  out  1          stage can accept a block
//  msg_in    in   GAMMA*K    message elements, element i at [GAMMA*i +: GAMMA]
//  key_in    in   GAMMA*K    key elements, same packing
//  prod_out  out  GAMMA*K    y_i results, same packing; feeds summation data_in
//  valid_out out  1          1-cycle pulse: prod_out holds a new complete block
//  busy      out  1          block in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; valid_out=0; busy=0; prod_out=0; internal slots, index and latches=0.
//  FSM: IDLE -> MUL -> DONE -> IDLE.
//   IDLE: in_ready=1. On valid_in=1 at an edge: latch msg_in/key_in, idx=0, go to MUL.
//   MUL: each cycle writes slot[idx] = (m_idx * k_idx) % P.
//    Product is full 2*GAMMA bits; reduction is on the full product.
//    Operands >= P are legal.
//    idx increments; when idx==K-1 is written, go to DONE.
//   DONE: copy all slots to prod_out; assert valid_out for exactly that one cycle; return to IDLE.
//  in_ready=0 in MUL and DONE; valid_in is ignored there. Inputs are not queued, and latched operands are unaffected.
//  Latency: block accepted at edge T; valid_out high in the cycle after edge T+K+1.
//  Throughput: one block per K+2 cycles. Next accept is possible at the edge that ends the valid_out cycle.
//  prod_out holds its last value until the next DONE; it never shows partial results.
//  valid_in held continuously: a new block is accepted every K+2 cycles, with no duplicates.
//  K=1: MUL lasts one cycle.
//  idx width is clog2(K), minimum 1. idx never exceeds K-1.
//  Reset mid-block (MUL or DONE): the block is aborted; no valid_out; all outputs return to reset values.
// CONFIGURATION
//  MMH_MUL_PIPE_EN defined:
//   - Raw product is registered before the % P reduction, giving a 2-cycle multiply-reduce pipeline.
//   - MUL lasts K+1 cycles, including one drain cycle.
//   - Latency is K+3; throughput is one block per K+3 cycles.
//   - Slot contents and all other rules are unchanged.
//  MMH_MUL_PIPE_EN undefined: single-cycle combinational multiply+reduce, latency K+2 as above.
// TESTING (GAMMA=13, K=16, P=127 unless stated)
//  1. Reset: rst pulse mid-run -> valid_out=0, in_ready=1, prod_out=0 immediately (asynchronous).
//  2. m_i=1, k_i=i -> y_i=i for all i; valid_out high exactly once, K+2 cycles after accept.
//  3. All m_i=k_i=100 -> every y_i=94 (10000 mod 127).
//     All m_i=k_i=8191 -> every y_i=32.
//  4. Back-to-back: valid_in held high with two different blocks ->
//     - second block accepted only at the end of the first block's valid_out cycle;
//     - two distinct pulses, K+2 cycles apart;
//     - valid_in changes during MUL are ignored.
//  5. Assert rst at idx=7 of a block, then offer a new block ->
//     - no valid_out for the aborted block;
//     - new block's results are correct.
//  6. Repeat tests 2-3 with MMH_MUL_PIPE_EN defined -> same y_i, latency K+3.

Source files
------------

// File: rtl/mmh_modmul_stage.sv
// MMH modular multiply stage: y_i = (m_i * k_i) mod P, one element per cycle, whole block out at once.
// Optional macro MMH_MUL_PIPE_EN registers the raw product ahead of the % P reduction.
module mmh_modmul_stage #(
  parameter int          GAMMA = 13,
  parameter int          K     = 16,
  parameter logic [63:0] P     = 64'h7F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic [GAMMA*K-1:0] msg_in,
  input  logic [GAMMA*K-1:0] key_in,
  output logic [GAMMA*K-1:0] prod_out,
  output logic               valid_out,
  output logic               busy
);

  localparam int                 IW   = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0]      LAST = IW'(K - 1);
  localparam logic [2*GAMMA-1:0] P_W  = (2*GAMMA)'(P);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [GAMMA*K-1:0]   r_msg, r_key, r_prod_out, w_slots_flat;
  logic [IW-1:0]        r_idx;
  logic                 r_valid_out;
  logic [GAMMA-1:0]     w_m, w_k, w_red;
  logic [2*GAMMA-1:0]   w_prod;
  logic                 w_wr_en, w_last_wr;
  logic [IW-1:0]        w_wr_idx;

  assign w_m    = r_msg[GAMMA*r_idx +: GAMMA];
  assign w_k    = r_key[GAMMA*r_idx +: GAMMA];
  assign w_prod = {{GAMMA{1'b0}}, w_m} * {{GAMMA{1'b0}}, w_k};

`ifdef MMH_MUL_PIPE_EN
  // Stage 1 holds the raw product; stage 2 reduces it and writes the slot it belongs to.
  logic [2*GAMMA-1:0] r_prod;
  logic [IW-1:0]      r_pidx;
  logic               r_pvld, r_drain;

  assign w_red     = GAMMA'(r_prod % P_W);
  assign w_wr_en   = (r_state == S_MUL) && r_pvld;
  assign w_wr_idx  = r_pidx;
  assign w_last_wr = r_pvld && (r_pidx == LAST);
`else
  assign w_red     = GAMMA'(w_prod % P_W);
  assign w_wr_en   = (r_state == S_MUL);
  assign w_wr_idx  = r_idx;
  assign w_last_wr = (r_idx == LAST);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      logic [GAMMA-1:0] r_slot;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_slot <= '0;
        else if (w_wr_en && (w_wr_idx == IW'(gi)))
          r_slot <= w_red;
      end
      assign w_slots_flat[GAMMA*gi +: GAMMA] = r_slot;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_in) w_next = S_MUL;
      S_MUL:   if (w_last_wr) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg       <= '0;
      r_key       <= '0;
      r_idx       <= '0;
      r_prod_out  <= '0;
      r_valid_out <= 1'b0;
`ifdef MMH_MUL_PIPE_EN
      r_prod      <= '0;
      r_pidx      <= '0;
      r_pvld      <= 1'b0;
      r_drain     <= 1'b0;
`endif
    end else begin
      r_valid_out <= 1'b0;
`ifdef MMH_MUL_PIPE_EN
      r_pvld      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_msg   <= msg_in;
            r_key   <= key_in;
            r_idx   <= '0;
`ifdef MMH_MUL_PIPE_EN
            r_drain <= 1'b0;
`endif
          end
        end
        S_MUL: begin
`ifdef MMH_MUL_PIPE_EN
          // After the last element is issued, idx parks at K-1 while the pipe drains.
          r_prod <= w_prod;
          r_pidx <= r_idx;
          r_pvld <= !r_drain;
          if (r_idx == LAST)
            r_drain <= 1'b1;
          else
            r_idx <= r_idx + 1'b1;
`else
          if (r_idx != LAST)
            r_idx <= r_idx + 1'b1;
`endif
        end
        S_DONE: begin
          r_prod_out  <= w_slots_flat;
          r_valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign prod_out  = r_prod_out;
  assign valid_out = r_valid_out;

endmodule
